// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the eight-requester round-robin arbiter.
// Contents: requester count, index width, FSM state type, index type.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and rr_arbiter_8.
//   req       : request vector, bit i is requester i
//   gnt_idx   : index of current owner (select input of the 3-to-8 decoder)
//   gnt_valid : high while a grant is active
//   timeout   : one-cycle pulse when a grant is ended by the hold limit
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  idx_t             gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, input gnt_idx, input gnt_valid, input timeout);
  modport slave  (input req, output gnt_idx, output gnt_valid, output timeout);

endinterface

// File: rtl/rr_arbiter_8_rr_pick.sv
// Combinational rotating-priority search.
//   req : request vector
//   ptr : highest-priority position; search order is ptr, ptr+1, ... ptr+7 (mod 8)
//   any : at least one request is set
//   idx : first set request in search order (0 when any is low)
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic             any,
  output idx_t             idx
);

  idx_t pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = idx_t'(ptr + i[IDX_W-1:0]);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with hold-time limit.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : rr_arbiter_8_if.slave (req in; gnt_idx, gnt_valid, timeout out)
// Parameter MAX_HOLD (0..255): maximum consecutive granted cycles, 0 = unlimited.
// All outputs are registered; an IDLE cycle always separates two grants.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_8_if.slave bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t state, state_d;
  idx_t       ptr, ptr_d;
  idx_t       gnt_idx, gnt_idx_d;
  logic       gnt_valid, gnt_valid_d;
  logic       timeout, timeout_d;
  logic [7:0] hold_cnt, hold_d;

  logic       pick_any;
  idx_t       pick_idx;
  logic       owner_req;
  logic       hold_limit;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req  = bus.req[gnt_idx];
  assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
      hold_cnt  <= hold_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (pick_any) state_d = GRANT;
      GRANT: if (!owner_req || hold_limit) state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter.
  // A dropped request takes precedence over the hold limit, so a release
  // coinciding with the limit is a normal one without a timeout pulse.
  always_comb begin
    ptr_d       = ptr;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;
    hold_d      = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_valid_d = 1'b0;
          ptr_d       = idx_t'(gnt_idx + 3'd1);
        end else if (hold_limit) begin
          gnt_valid_d = 1'b0;
          ptr_d       = idx_t'(gnt_idx + 3'd1);
          timeout_d   = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          hold_d = hold_cnt + 8'd1;
        end
      end
    endcase
  end

  assign bus.gnt_idx   = gnt_idx;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with four instances differing in MAX_HOLD
// (16, 4, 2, 0) sharing one clock and reset.
module tb_rr_arbiter_8;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_8_if if_a ();
  rr_arbiter_8_if if_b ();
  rr_arbiter_8_if if_c ();
  rr_arbiter_8_if if_d ();

  rr_arbiter_8 #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  rr_arbiter_8 #(.MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  rr_arbiter_8 #(.MAX_HOLD(2))  dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  rr_arbiter_8 #(.MAX_HOLD(0))  dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if_a.req = '0; if_b.req = '0; if_c.req = '0; if_d.req = '0;
    do_reset();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx, if_a.timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b idx=%0d timeout=%b, want 0 0 0",
               if_a.gnt_valid, if_a.gnt_idx, if_a.timeout);
    end
    checks++;
    if (dut_a.ptr !== 3'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dut_a.ptr);
    end
  endtask

  task automatic test_single();
    do_reset();
    if_a.req = 8'b0010_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if_a.gnt_valid, if_a.gnt_idx, if_a.timeout} !== {1'b1, 3'd5, 1'b0}) begin
        errors++;
        $display("FAIL single_grant[%0d]: got valid=%b idx=%0d timeout=%b, want 1 5 0",
                 i, if_a.gnt_valid, if_a.gnt_idx, if_a.timeout);
      end
    end
    if_a.req = '0;
    step();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx, if_a.timeout} !== {1'b0, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL single_release: got valid=%b idx=%0d timeout=%b, want 0 5 0",
               if_a.gnt_valid, if_a.gnt_idx, if_a.timeout);
    end
    checks++;
    if (dut_a.ptr !== 3'd6) begin
      errors++;
      $display("FAIL single_ptr: got %0d want 6", dut_a.ptr);
    end
  endtask

  task automatic test_rotation();
    idx_t exp_order [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
    do_reset();
    for (int g = 0; g < 4; g++) begin
      if_a.req = 8'b1000_0001;
      for (int c = 0; c < 2; c++) begin
        step();
        checks++;
        if ({if_a.gnt_valid, if_a.gnt_idx, if_a.timeout} !== {1'b1, exp_order[g], 1'b0}) begin
          errors++;
          $display("FAIL rotation_grant[%0d.%0d]: got valid=%b idx=%0d, want 1 %0d",
                   g, c, if_a.gnt_valid, if_a.gnt_idx, exp_order[g]);
        end
      end
      if_a.req = 8'b1000_0001 & ~(8'd1 << exp_order[g]);
      step();
      checks++;
      if ({if_a.gnt_valid, if_a.timeout} !== 2'b00) begin
        errors++;
        $display("FAIL rotation_idle[%0d]: got valid=%b timeout=%b, want 0 0",
                 g, if_a.gnt_valid, if_a.timeout);
      end
    end
    if_a.req = '0;
    step();
  endtask

  task automatic test_wrap();
    if_a.req = 8'b0100_0000;
    step();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL wrap_grant6: got valid=%b idx=%0d, want 1 6", if_a.gnt_valid, if_a.gnt_idx);
    end
    if_a.req = '0;
    step();
    checks++;
    if (dut_a.ptr !== 3'd7) begin
      errors++;
      $display("FAIL wrap_ptr: got %0d want 7", dut_a.ptr);
    end
    if_a.req = 8'b0100_0001;
    step();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wrap_grant0: got valid=%b idx=%0d, want 1 0", if_a.gnt_valid, if_a.gnt_idx);
    end
    if_a.req = '0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    if_a.req = 8'b0000_1000;
    step();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL midrst_grant3: got valid=%b idx=%0d, want 1 3", if_a.gnt_valid, if_a.gnt_idx);
    end
    if_a.req = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx, if_a.timeout} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b idx=%0d timeout=%b, want 0 0 0",
               if_a.gnt_valid, if_a.gnt_idx, if_a.timeout);
    end
    step();
    checks++;
    if ({if_a.gnt_valid, if_a.gnt_idx} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL midrst_first: got valid=%b idx=%0d, want 1 0", if_a.gnt_valid, if_a.gnt_idx);
    end
    if_a.req = '0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    if_b.req = 8'b0000_0100;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({if_b.gnt_valid, if_b.gnt_idx, if_b.timeout} !== {1'b1, 3'd2, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: got valid=%b idx=%0d timeout=%b, want 1 2 0",
                 i, if_b.gnt_valid, if_b.gnt_idx, if_b.timeout);
      end
    end
    step();
    checks++;
    if ({if_b.gnt_valid, if_b.timeout} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_pulse: got valid=%b timeout=%b, want 0 1", if_b.gnt_valid, if_b.timeout);
    end
    step();
    checks++;
    if ({if_b.gnt_valid, if_b.gnt_idx, if_b.timeout} !== {1'b1, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_regrant: got valid=%b idx=%0d timeout=%b, want 1 2 0",
               if_b.gnt_valid, if_b.gnt_idx, if_b.timeout);
    end
    // Owner releases on the very edge the hold limit is reached.
    do_reset();
    if_b.req = 8'b0000_0100;
    for (int i = 0; i < 4; i++) step();
    if_b.req = '0;
    step();
    checks++;
    if ({if_b.gnt_valid, if_b.timeout} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_simul: got valid=%b timeout=%b, want 0 0", if_b.gnt_valid, if_b.timeout);
    end
    step();
    checks++;
    if ({if_b.gnt_valid, if_b.timeout} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_simul_after: got valid=%b timeout=%b, want 0 0", if_b.gnt_valid, if_b.timeout);
    end
  endtask

  task automatic test_fairness();
    logic [4:0] exp;
    do_reset();
    if_c.req = 8'hFF;
    for (int k = 0; k < 48; k++) begin
      step();
      if (k % 3 == 2) exp = {1'b0, 3'((k / 3) % 8), 1'b1};
      else            exp = {1'b1, 3'((k / 3) % 8), 1'b0};
      checks++;
      if ({if_c.gnt_valid, if_c.gnt_idx, if_c.timeout} !== exp) begin
        errors++;
        $display("FAIL fairness[%0d]: got valid=%b idx=%0d timeout=%b, want %b %0d %b",
                 k, if_c.gnt_valid, if_c.gnt_idx, if_c.timeout, exp[4], exp[3:1], exp[0]);
      end
    end
    if_c.req = '0;
    step();
  endtask

  task automatic test_unlimited();
    int bad = 0;
    do_reset();
    if_d.req = 8'b0000_0010;
    for (int k = 0; k < 300; k++) begin
      step();
      if ({if_d.gnt_valid, if_d.gnt_idx, if_d.timeout} !== {1'b1, 3'd1, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL unlimited_hold: got %0d off-grant cycles, want 0", bad);
    end
    checks++;
    if (dut_d.hold_cnt !== 8'd255) begin
      errors++;
      $display("FAIL unlimited_sat: got hold_cnt=%0d want 255", dut_d.hold_cnt);
    end
    if_d.req = '0;
    step();
    checks++;
    if ({if_d.gnt_valid, if_d.timeout} !== 2'b00) begin
      errors++;
      $display("FAIL unlimited_release: got valid=%b timeout=%b, want 0 0", if_d.gnt_valid, if_d.timeout);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
    test_timeout();
    test_fairness();
    test_unlimited();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
